johnson_phase_tracker: RTL

- Sits directly downstream of the team's 32-bit Johnson counter and consumes its Q bus every sampled cycle.
- Validates each code word as a legal Johnson state and decodes it to a binary phase index (0..2*WIDTH-1).
- Checks that successive samples advance by exactly one phase, runs a lock state machine, and reports wrap and error events to the control logic.

---
 rtl/johnson_phase_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/johnson_phase_tracker.sv
// Johnson code phase tracker: decodes each sampled code word to a phase index,
// checks phase-to-phase succession, and tracks lock with error reporting.
module johnson_phase_tracker #(
    parameter  int WIDTH      = 32,
    parameter  int LOCK_COUNT = 4,
    parameter  int MISS_LIMIT = 2,
    parameter  int ERRCNT_W   = 16,
    localparam int PW         = $clog2(2 * WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    code_in,
    input  logic                code_valid,
    output logic [PW-1:0]       phase,
    output logic                phase_valid,
    output logic                wrap,
    output logic                locked,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                clr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]    ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       ONE_PW     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       LAST_PHASE = PW'(2 * WIDTH - 1);
    localparam logic [PW-1:0]       WIDTH_PW   = PW'(WIDTH);
    localparam logic [ERRCNT_W-1:0] ONE_ERR    = {{(ERRCNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]          LOCK_CNT8  = 8'(LOCK_COUNT);
    localparam logic [7:0]          MISS_LIM8  = 8'(MISS_LIMIT);

    state_t                state_q;
    logic [PW-1:0]         phase_q;
    logic                  phaseValid_q;
    logic                  wrap_q;
    logic                  locked_q;
    logic                  err_q;
    logic [ERRCNT_W-1:0]   errCount_q;
    logic [ERRCNT_W-1:0]   errCount_d;
    logic [7:0]            good_q;
    logic [7:0]            miss_q;

    logic [PW-1:0]         onesCnt;
    logic [PW-1:0]         zerosCnt;
    logic                  lowOnes;
    logic                  highOnes;
    logic                  isLegal;
    logic [PW-1:0]         decPhase;
    logic [PW-1:0]         succPhase;
    logic                  isFirst;
    logic                  isHold;
    logic                  isStep;
    logic                  isJump;
    logic                  isErr;
    logic [7:0]            goodNext;
    logic [7:0]            missNext;

    // A legal word is either 0..01..1 (c & (c+1) == 0) or 1..10..0 (same test on ~c).
    always_comb begin
        onesCnt  = '0;
        zerosCnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onesCnt  = onesCnt  + PW'(code_in[i]);
            zerosCnt = zerosCnt + PW'(!code_in[i]);
        end
    end

    assign lowOnes   = ((code_in & (code_in + ONE_W)) == '0);
    assign highOnes  = ((~code_in & (~code_in + ONE_W)) == '0);
    assign isLegal   = lowOnes | highOnes;
    assign decPhase  = lowOnes ? onesCnt : (WIDTH_PW + zerosCnt);
    assign succPhase = (phase_q == LAST_PHASE) ? '0 : (phase_q + ONE_PW);

    assign isFirst  = isLegal && (state_q == IDLE);
    assign isHold   = isLegal && !isFirst && phaseValid_q && (decPhase == phase_q);
    assign isStep   = isLegal && !isFirst && !isHold && (decPhase == succPhase);
    assign isJump   = isLegal && !isFirst && !isHold && !isStep;
    assign isErr    = code_valid && (!isLegal || isJump);
    assign goodNext = good_q + 8'd1;
    assign missNext = miss_q + 8'd1;

    // A clear coinciding with a new error leaves exactly that one error counted.
    always_comb begin
        errCount_d = errCount_q;
        if (clr_err) begin
            errCount_d = isErr ? ONE_ERR : '0;
        end else if (isErr && (errCount_q != '1)) begin
            errCount_d = errCount_q + ONE_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            phaseValid_q <= 1'b0;
            wrap_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            errCount_q   <= '0;
            good_q       <= '0;
            miss_q       <= '0;
        end else begin
            wrap_q     <= 1'b0;
            err_q      <= isErr;
            errCount_q <= errCount_d;
            if (code_valid) begin
                if (isLegal) begin
                    phase_q      <= decPhase;
                    phaseValid_q <= 1'b1;
                end else begin
                    phaseValid_q <= 1'b0;
                end
                wrap_q <= isStep && (phase_q == LAST_PHASE);

                case (state_q)
                    IDLE: begin
                        if (isFirst) begin
                            state_q <= ACQUIRE;
                            good_q  <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (!isLegal) begin
                            state_q <= IDLE;
                            good_q  <= '0;
                        end else if (isJump) begin
                            good_q <= '0;
                        end else if (isStep) begin
                            good_q <= goodNext;
                            if (goodNext == LOCK_CNT8) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (isStep) begin
                            miss_q <= '0;
                        end else if (isJump || !isLegal) begin
                            if (missNext == MISS_LIM8) begin
                                state_q  <= isJump ? ACQUIRE : IDLE;
                                locked_q <= 1'b0;
                                good_q   <= '0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= missNext;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phaseValid_q;
    assign wrap        = wrap_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = errCount_q;

endmodule
